// File: rtl/cache_fill_ctrl.sv
// Block fill on cache miss: WORDS pipelined reads, returned words streamed into the data array, then a tag write; stalls the pipeline throughout.
// Requests start the cycle after the miss and fill ends on the last returned word; memory has no backpressure, and a stalled return holds FILL. CACHE_FILL_WRAP_EN selects critical-word-first order.
module cache_fill_ctrl #(
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             miss_detected,
   input  logic [15:0]      miss_address,
   input  logic             memory_data_valid,
   input  logic [15:0]      memory_data,
   output logic             fsm_busy,
   output logic             mem_en,
   output logic [15:0]      memory_address,
   output logic             write_data_array,
   output logic [WORDS-1:0] data_word_en,
   output logic [15:0]      write_data,
   output logic             write_tag_array
);

   localparam int WIDX = $clog2(WORDS);
   localparam int CW   = WIDX + 1;

   // Nothing to build for the memory latency: the fill counts returned words instead.
   if (WORDS < 2 || MEM_LAT < 1) begin : g_bad_params
   end

   typedef enum logic {IDLE, FILL} state_t;

   state_t          state;
   logic [15:0]     base;
   logic [CW-1:0]   issue_cnt;
   logic [CW-1:0]   recv_cnt;
   logic [WIDX-1:0] start_word;
   logic [WIDX-1:0] miss_start;
   logic [WIDX-1:0] issue_idx;
   logic [WIDX-1:0] recv_idx;
   logic [15:0]     miss_base;

`ifdef CACHE_FILL_WRAP_EN
   assign miss_start = miss_address[WIDX:1];
`else
   assign miss_start = '0;
`endif

   function automatic logic [15:0] word_off(input logic [WIDX-1:0] idx);
      return 16'({idx, 1'b0});
   endfunction

   assign miss_base = miss_address & 16'hFFF0;
   assign issue_idx = start_word + issue_cnt[WIDX-1:0];
   assign recv_idx  = start_word + recv_cnt[WIDX-1:0];

   assign fsm_busy   = (state == FILL) | miss_detected;
   assign write_data = memory_data;

   always_comb begin
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      data_word_en     = '0;
      if (state == FILL && memory_data_valid) begin
         write_data_array       = 1'b1;
         data_word_en[recv_idx] = 1'b1;
         write_tag_array        = (recv_cnt == CW'(WORDS - 1));
      end
   end

   // The request strobe is registered, so the first request is scheduled in the
   // miss cycle itself and issue_cnt counts requests already placed on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         base           <= '0;
         issue_cnt      <= '0;
         recv_cnt       <= '0;
         start_word     <= '0;
         mem_en         <= 1'b0;
         memory_address <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_en         <= 1'b0;
               memory_address <= '0;
               if (miss_detected) begin
                  base           <= miss_base;
                  start_word     <= miss_start;
                  issue_cnt      <= CW'(1);
                  recv_cnt       <= '0;
                  mem_en         <= 1'b1;
                  memory_address <= miss_base + word_off(miss_start);
                  state          <= FILL;
               end
            end
            FILL: begin
               if (issue_cnt < CW'(WORDS)) begin
                  mem_en         <= 1'b1;
                  memory_address <= base + word_off(issue_idx);
                  issue_cnt      <= issue_cnt + CW'(1);
               end else begin
                  mem_en         <= 1'b0;
                  memory_address <= '0;
               end
               if (memory_data_valid) begin
                  recv_cnt <= recv_cnt + CW'(1);
                  if (recv_cnt == CW'(WORDS - 1)) begin
                     state          <= IDLE;
                     mem_en         <= 1'b0;
                     memory_address <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
